inv_sub_bytes_seq: RTL and testbench

INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

---
 rtl/inv_sub_bytes_seq.sv | 120 ++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes over a 128-bit state.
// BYTES_PER_CYCLE inverse S-box lanes walk the state group by group.
module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data
);

    localparam int NGRP = 16 / BYTES_PER_CYCLE;
    localparam int CW = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NGRP - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 ||
          BYTES_PER_CYCLE == 4 || BYTES_PER_CYCLE == 8 ||
          BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // Row r holds inverse S-box entries 16*r .. 16*r+15.
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:127]  data_q, data_d;
    int            pos;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        pos       = 0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
                    pos = int'(cnt_q) * BYTES_PER_CYCLE + i;
                    data_d[pos*8 +: 8] = inv_sbox(data_q[pos*8 +: 8]);
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any handshake; the stale register is never presented.
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            data_d  = data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: five instances (BPC 4,1,2,8,16),
// reference inverse S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_seq;

    localparam int N = 5;
    localparam int BPCS [N] = '{4, 1, 2, 8, 16};

    logic         clk = 1'b0;
    logic         rst;
    logic         clear     [N];
    logic         in_valid  [N];
    logic         in_ready  [N];
    logic         out_valid [N];
    logic         out_ready [N];
    logic [0:127] in_data   [N];
    logic [0:127] out_data  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPCS[g])) u_dut (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           total = 0;
    int           bad = 0;
    logic [7:0]   inv_tab [256];
    logic [0:127] expq [N][$];
    int           acc_cyc [N];
    int           last_acc [N];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = (v << n) | (v >> (8 - n));
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] v;
        v = '0;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [0:127] ref_inv(input logic [0:127] d);
        logic [0:127] r;
        r = '0;
        for (int b = 0; b < 16; b++)
            r[b*8 +: 8] = inv_tab[d[b*8 +: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the instance idle; returns #1 after the accept edge.
    task automatic send(input int k, input logic [0:127] d,
                        input logic [0:127] exp, input bit tput);
        chk($sformatf("in_ready_pre_accept[%0d]", k), 128'(in_ready[k]), 1);
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        expq[k].push_back(exp);
        acc_cyc[k] = cyc;
        if (tput)
            chk($sformatf("throughput[%0d]", k), 128'(acc_cyc[k] - last_acc[k]),
                128'(16 / BPCS[k] + 2));
        last_acc[k] = cyc;
    endtask

    // Waits for a result, scores it, optionally stalls, then consumes it.
    task automatic recv(input int k, input int hold);
        logic [0:127] exp;
        bit seen;
        seen = 1'b0;
        exp = '0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (out_valid[k] === 1'b1) seen = 1'b1;
        end
        chk($sformatf("out_valid_seen[%0d]", k), 128'(seen), 1);
        chk($sformatf("latency[%0d]", k), 128'(cyc - acc_cyc[k]),
            128'(16 / BPCS[k]));
        if (expq[k].size() > 0) exp = expq[k].pop_front();
        chk($sformatf("out_data[%0d]", k), out_data[k], exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid[k] = (i == 3);
            in_data[k]  = ~exp;
            chk("bp_out_valid", 128'(out_valid[k]), 1);
            chk("bp_out_data", out_data[k], exp);
            chk("bp_in_ready", 128'(in_ready[k]), 0);
        end
        out_ready[k] = 1'b1;
        in_valid[k]  = 1'b1;
        in_data[k]   = ~exp;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("idle_in_ready[%0d]", k), 128'(in_ready[k]), 1);
        chk($sformatf("idle_out_valid[%0d]", k), 128'(out_valid[k]), 0);
        chk($sformatf("idle_out_data_kept[%0d]", k), out_data[k], exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:127] d;
        logic [0:127] pb_exp;
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            clear[k]     = 1'b0;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            in_data[k]   = '0;
            acc_cyc[k]   = 0;
            last_acc[k]  = 0;
        end
        for (int x = 0; x < 256; x++) inv_tab[sbox_fwd(8'(x))] = 8'(x);

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid[0]), 0);
        chk("rst_in_ready", 128'(in_ready[0]), 1);
        chk("rst_out_data", out_data[0], '0);
        rst = 1'b0;

        send(0, {16{8'h63}}, '0, 1'b0);
        recv(0, 0);

        pb_exp = {8'h52, 8'h09, 8'hff, 8'h01, {12{8'h52}}};
        send(0, {8'h00, 8'h01, 8'h16, 8'h7c, {12{8'h00}}}, pb_exp, 1'b0);
        recv(0, 0);

        d = {$urandom, $urandom, $urandom, $urandom};
        out_ready[0] = 1'b0;
        send(0, d, ref_inv(d), 1'b0);
        recv(0, 10);

        d = {$urandom, $urandom, $urandom, $urandom};
        send(0, d, ref_inv(d), 1'b0);
        @(posedge clk);
        #1;
        clear[0] = 1'b1;
        @(posedge clk);
        #1;
        clear[0] = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 128'(in_ready[0]), 1);
        chk("abort_out_valid", 128'(out_valid[0]), 0);
        expq[0].delete();

        clear[0]    = 1'b1;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        clear[0]    = 1'b0;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("clear_beats_in_valid", 128'(in_ready[0]), 1);

        d = {$urandom, $urandom, $urandom, $urandom};
        send(0, d, ref_inv(d), 1'b0);
        recv(0, 0);

        send(0, {16{8'haa}}, ref_inv({16{8'haa}}), 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid[0]), 0);
        chk("arst_in_ready", 128'(in_ready[0]), 1);
        chk("arst_out_data", out_data[0], '0);
        #1;
        rst = 1'b0;
        expq[0].delete();
        d = {$urandom, $urandom, $urandom, $urandom};
        send(0, d, ref_inv(d), 1'b0);
        recv(0, 0);

        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 256; i++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                send(k, d, ref_inv(d), i != 0);
                recv(k, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
